wordcell_access_ctrl: RTL and testbench

Sequential initiator that drives a bank of NAND-latch word cells through their `op` / `sel_x` / `in_bus` / `out_bus` interface. Upstream logic issues read and write requests over a valid/ready handshake. The block sequences the cell control lines with registered, glitch-free timing and returns one response per request. It sits between the system bus logic and the word-cell array, and replaces hand-driven cell stimulus.

---
 rtl/wordcell_ctrl_pkg.sv | 24 ++
 rtl/wordcell_addr_decode.sv | 23 ++
 rtl/wordcell_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_wordcell_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wordcell_ctrl_pkg.sv
// Shared types and constants for the word-cell access controller.
// The optional write-verify states are present only with WORDCELL_WRITE_VERIFY_EN.
package wordcell_ctrl_pkg;

    localparam int WORDS_DEF = 8;
    localparam int WIDTH_DEF = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SAMPLE,
        RESP
`ifdef WORDCELL_WRITE_VERIFY_EN
        ,
        VSETUP,
        VSAMPLE
`endif
    } state_t;

endpackage

// File: rtl/wordcell_addr_decode.sv
// Combinational word-index to one-hot decode with an in-range flag.
// Indices at or above WORDS decode to an all-zero select.
module wordcell_addr_decode
    import wordcell_ctrl_pkg::*;
#(
    parameter int WORDS  = WORDS_DEF,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [WORDS-1:0]  onehot,
    output logic              in_range
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        onehot   = '0;
        in_range = (int'(addr) < WORDS);
        for (int i = 0; i < WORDS; i++) begin
            onehot[i] = (int'(addr) == i);
        end
    end

endmodule

// File: rtl/wordcell_access_ctrl.sv
// Request/response sequencer for a bank of NAND-latch word cells; every output is a flop.
// Define WORDCELL_WRITE_VERIFY_EN to read back each write and flag mismatches.
module wordcell_access_ctrl
    import wordcell_ctrl_pkg::*;
#(
    parameter int WORDS  = WORDS_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              cell_op,
    output logic [WORDS-1:0]  cell_sel,
    output logic [WIDTH-1:0]  cell_in_bus,
    input  logic [WIDTH-1:0]  cell_out_bus
);

    state_t state, state_d;

    logic             is_write;
    logic             addr_ok;
    logic             accept;
    logic [WORDS-1:0] dec_onehot;
    logic             dec_in_range;
`ifdef WORDCELL_WRITE_VERIFY_EN
    logic [WIDTH-1:0] wdata_q;
`endif

    logic             req_ready_d;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_d;
    logic             rsp_err_d;
    logic             cell_op_d;
    logic [WORDS-1:0] cell_sel_d;
    logic [WIDTH-1:0] cell_in_bus_d;

    wordcell_addr_decode #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr     (req_addr),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    assign accept = (state == IDLE) && req_valid && req_ready;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = is_write ? STROBE : SAMPLE;
`ifdef WORDCELL_WRITE_VERIFY_EN
            STROBE:  state_d = VSETUP;
            VSETUP:  state_d = VSAMPLE;
            VSAMPLE: state_d = RESP;
`else
            STROBE:  state_d = RESP;
`endif
            SAMPLE:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the flops present them in that state.
    always_comb begin
        req_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == RESP);
        cell_op_d     = OP_READ;
        cell_sel_d    = '0;
        cell_in_bus_d = '0;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;

        case (state_d)
            // SETUP is only ever entered straight from an accepted request.
            SETUP: begin
                cell_sel_d    = dec_onehot;
                cell_in_bus_d = req_write ? req_wdata : '0;
            end
            STROBE: begin
                cell_sel_d    = cell_sel;
                cell_in_bus_d = cell_in_bus;
                cell_op_d     = addr_ok ? OP_WRITE : OP_READ;
            end
`ifdef WORDCELL_WRITE_VERIFY_EN
            SAMPLE, VSETUP, VSAMPLE: cell_sel_d = cell_sel;
`else
            SAMPLE:  cell_sel_d = cell_sel;
`endif
            default: ;
        endcase

        case (state)
            SAMPLE: begin
                rsp_rdata_d = addr_ok ? cell_out_bus : '0;
                rsp_err_d   = !addr_ok;
            end
`ifdef WORDCELL_WRITE_VERIFY_EN
            VSAMPLE: begin
                rsp_rdata_d = addr_ok ? cell_out_bus : '0;
                rsp_err_d   = !addr_ok || (cell_out_bus != wdata_q);
            end
`else
            STROBE: begin
                rsp_rdata_d = '0;
                rsp_err_d   = !addr_ok;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: clocked blocks use non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            cell_op     <= OP_READ;
            cell_sel    <= '0;
            cell_in_bus <= '0;
            is_write    <= 1'b0;
            addr_ok     <= 1'b0;
`ifdef WORDCELL_WRITE_VERIFY_EN
            wdata_q     <= '0;
`endif
        end else begin
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            cell_op     <= cell_op_d;
            cell_sel    <= cell_sel_d;
            cell_in_bus <= cell_in_bus_d;
            if (accept) begin
                is_write <= req_write;
                addr_ok  <= dec_in_range;
`ifdef WORDCELL_WRITE_VERIFY_EN
                wdata_q  <= req_wdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_wordcell_access_ctrl.sv
// Bench: an 8-word and a 6-word controller share one request stream, each driving a
// behavioural NAND-latch array; responses are checked against a word-level scoreboard.
module tb_wordcell_access_ctrl;

`ifdef WORDCELL_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WR_LAT = VERIFY ? 5 : 3;
    localparam int RD_LAT = 3;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;

    logic       req_ready_a, rsp_valid_a, rsp_err_a, cell_op_a;
    logic [7:0] rsp_rdata_a, cell_sel_a, cell_in_bus_a, cell_out_bus_a;
    logic       req_ready_b, rsp_valid_b, rsp_err_b, cell_op_b;
    logic [7:0] rsp_rdata_b, cell_in_bus_b, cell_out_bus_b;
    logic [5:0] cell_sel_b;

    logic       stuck0;
    logic [7:0] cells_a [8] = '{default: 8'h00};
    logic [7:0] cells_b [6] = '{default: 8'h00};
    logic [7:0] exp_a [8]   = '{default: 8'h00};
    logic [7:0] exp_b [6]   = '{default: 8'h00};

    int n_cmp = 0;
    int n_mis = 0;

    wordcell_access_ctrl #(.WORDS(8), .WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .cell_op(cell_op_a), .cell_sel(cell_sel_a), .cell_in_bus(cell_in_bus_a),
        .cell_out_bus(cell_out_bus_a)
    );

    wordcell_access_ctrl #(.WORDS(6), .WIDTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .cell_op(cell_op_b), .cell_sel(cell_sel_b), .cell_in_bus(cell_in_bus_b),
        .cell_out_bus(cell_out_bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level-sensitive cell arrays: transparent while op is high; bit 0 can be forced stuck-at-0.
    always @(cell_op_a or cell_sel_a or cell_in_bus_a or stuck0)
        if (cell_op_a)
            for (int i = 0; i < 8; i++)
                if (cell_sel_a[i]) cells_a[i] = cell_in_bus_a & (stuck0 ? 8'hFE : 8'hFF);

    always @(cell_op_b or cell_sel_b or cell_in_bus_b or stuck0)
        if (cell_op_b)
            for (int i = 0; i < 6; i++)
                if (cell_sel_b[i]) cells_b[i] = cell_in_bus_b & (stuck0 ? 8'hFE : 8'hFF);

    always_comb begin
        cell_out_bus_a = 8'h00;
        for (int i = 0; i < 8; i++) if (cell_sel_a[i]) cell_out_bus_a |= cells_a[i];
    end

    always_comb begin
        cell_out_bus_b = 8'h00;
        for (int i = 0; i < 6; i++) if (cell_sel_b[i]) cell_out_bus_b |= cells_b[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!(req_ready_a && req_ready_b) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_wait", 32'(w < 20), 1);
    endtask

    task automatic do_req(input logic wr, input logic [2:0] addr, input logic [7:0] data, input int hold);
        logic       ok_b;
        logic [7:0] one_a, rb, er_a, er_b, sel1_a, in1_a, psel_a, pin_a;
        logic [5:0] one_b, sel1_b, psel_b;
        logic [7:0] pin_b;
        logic       ee_a, ee_b, pop_a, pop_b;
        int         lat, ops_a, ops_b, bad_a, bad_b;

        ok_b  = (addr < 3'd6);
        one_a = 8'd1 << addr;
        one_b = ok_b ? (6'd1 << addr) : 6'd0;
        rb    = data & (stuck0 ? 8'hFE : 8'hFF);
        if (wr) begin
            exp_a[addr] = rb;
            if (ok_b) exp_b[addr] = rb;
            er_a = VERIFY ? rb : 8'h00;
            ee_a = VERIFY && (rb != data);
            er_b = (VERIFY && ok_b) ? rb : 8'h00;
            ee_b = !ok_b || (VERIFY && (rb != data));
        end else begin
            er_a = exp_a[addr];
            ee_a = 1'b0;
            er_b = ok_b ? exp_b[addr] : 8'h00;
            ee_b = !ok_b;
        end

        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; ops_a = 0; ops_b = 0; bad_a = 0; bad_b = 0;
        pop_a = 1'b0; pop_b = 1'b0; psel_a = '0; psel_b = '0; pin_a = '0; pin_b = '0;
        sel1_a = '0; sel1_b = '0; in1_a = '0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_a || rsp_valid_b) break;
            if (lat == 1) begin
                sel1_a = cell_sel_a;
                sel1_b = cell_sel_b;
                in1_a  = cell_in_bus_a;
            end
            // op may only be high over a select/data that was already stable and one-hot.
            if (cell_op_a) begin
                ops_a++;
                if (psel_a != cell_sel_a || !$onehot(psel_a) || pin_a != cell_in_bus_a) bad_a++;
            end
            if (cell_op_b) begin
                ops_b++;
                if (psel_b != cell_sel_b || !$onehot(psel_b) || pin_b != cell_in_bus_b) bad_b++;
            end
            pop_a = cell_op_a; psel_a = cell_sel_a; pin_a = cell_in_bus_a;
            pop_b = cell_op_b; psel_b = cell_sel_b; pin_b = cell_in_bus_b;
        end

        check("rsp_latency", lat, wr ? WR_LAT : RD_LAT);
        check("rsp_valid_a", rsp_valid_a, 1);
        check("rsp_valid_b", rsp_valid_b, 1);
        check("setup_sel_a", sel1_a, one_a);
        check("setup_sel_b", sel1_b, one_b);
        check("setup_in_bus_a", in1_a, wr ? data : 8'h00);
        check("op_cycles_a", ops_a, wr ? 1 : 0);
        check("op_cycles_b", ops_b, (wr && ok_b) ? 1 : 0);
        check("op_glitch_a", bad_a, 0);
        check("op_glitch_b", bad_b, 0);
        check("resp_cells_idle_a", {cell_op_a, cell_sel_a, cell_in_bus_a}, 0);
        check("rdata_a", rsp_rdata_a, er_a);
        check("err_a", rsp_err_a, ee_a);
        check("rdata_b", rsp_rdata_b, er_b);
        check("err_b", rsp_err_b, ee_b);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid_a", rsp_valid_a, 1);
            check("hold_rdata_a", rsp_rdata_a, er_a);
            check("hold_rdata_b", rsp_rdata_b, er_b);
            check("hold_req_ready_a", req_ready_a, 0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid_a", rsp_valid_a, 0);
        check("post_hs_ready_a", req_ready_a, 1);
    endtask

    // Reset lands while the write strobe is high; the response must never appear.
    task automatic abort_write(input logic [2:0] addr, input logic [7:0] data);
        int seen = 0;
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_strobe_a", cell_op_a, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_op_a", cell_op_a, 0);
        check("abort_sel_a", cell_sel_a, 0);
        check("abort_op_b", cell_op_b, 0);
        check("abort_ready_a", req_ready_a, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid_a || rsp_valid_b) seen++;
        end
        check("abort_no_rsp", seen, 0);
        check("abort_ready_after", req_ready_a, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; stuck0 = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready_a", req_ready_a, 0);
        check("rst_outs_a", {rsp_valid_a, rsp_rdata_a, rsp_err_a, cell_op_a, cell_sel_a, cell_in_bus_a}, 0);
        check("rst_outs_b", {rsp_valid_b, rsp_rdata_b, rsp_err_b, cell_op_b, cell_sel_b, cell_in_bus_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready_a", req_ready_a, 1);
        check("rel_ready_b", req_ready_b, 1);

        do_req(1'b1, 3'd3, 8'h55, 0);
        do_req(1'b0, 3'd3, 8'h00, 0);
        do_req(1'b1, 3'd7, 8'hCC, 0);
        do_req(1'b1, 3'd0, 8'h11, 0);
        do_req(1'b0, 3'd7, 8'h00, 0);
        do_req(1'b0, 3'd0, 8'h00, 0);
        do_req(1'b0, 3'd3, 8'h00, 5);
        do_req(1'b1, 3'd6, 8'h3C, 1);

        if (VERIFY) begin
            stuck0 = 1'b1;
            do_req(1'b1, 3'd4, 8'h01, 0);
            stuck0 = 1'b0;
            do_req(1'b1, 3'd4, 8'h81, 0);
        end

        abort_write(3'd2, 8'hA5);
        do_req(1'b1, 3'd2, 8'h5A, 0);
        do_req(1'b0, 3'd2, 8'h00, 0);

        for (int n = 0; n < 40; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
